ex_div_ctrl: RTL and testbench



---
 rtl/ex_div_ctrl_pkg.sv | 15 +
 rtl/ex_div_if.sv | 27 ++
 rtl/ex_div_ctrl_div_step.sv | 22 ++
 rtl/ex_div_ctrl.sv | 135 +++++++++++++
 tb/tb_ex_div_ctrl.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/ex_div_ctrl_pkg.sv
// Shared definitions for the EX-stage divide controller: state encoding and
// the divide-by-zero quotient constant.
package ex_div_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_e;

    // Divide-by-zero returns an all-ones quotient; sliced to WIDTH at use.
    localparam logic [63:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/ex_div_if.sv
// Request/response bundle between the EX stage (master) and the shared
// multi-cycle divider (slave).
interface ex_div_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic             req_signed;
    logic [WIDTH-1:0] req_src1;
    logic [WIDTH-1:0] req_src2;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_quot;
    logic [WIDTH-1:0] resp_rem;
    logic             cancel;
    logic             busy;

    modport master (
        output req_valid, req_signed, req_src1, req_src2, resp_ready, cancel,
        input  req_ready, resp_valid, resp_quot, resp_rem, busy
    );

    modport slave (
        input  req_valid, req_signed, req_src1, req_src2, resp_ready, cancel,
        output req_ready, resp_valid, resp_quot, resp_rem, busy
    );
endinterface

// File: rtl/ex_div_ctrl_div_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder and subtract the divisor if it fits.
module ex_div_ctrl_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dvd_msb_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             quot_bit_o
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        shifted    = {rem_i, dvd_msb_i};
        trial      = shifted - {1'b0, divisor_i};
        // A clear top bit means no borrow, so the divisor fits.
        quot_bit_o = ~trial[WIDTH];
        rem_o      = quot_bit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end
endmodule

// File: rtl/ex_div_ctrl.sv
// Multi-cycle radix-2 restoring divider for div.w/div.wu/mod.w/mod.wu with a
// valid/ready request, held response and synchronous cancel.
module ex_div_ctrl
    import ex_div_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic         clk,
    input  logic         rst,
    ex_div_if.slave      div_if
);
    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_out_q, rem_out_d;
    logic             busy_q, busy_d;
    logic             resp_valid_q, resp_valid_d;

    logic             accept;
    logic             src1_neg;
    logic             src2_neg;
    logic [WIDTH-1:0] step_rem;
    logic             step_quot_bit;

    ex_div_ctrl_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i      (acc_q),
        .dvd_msb_i  (dvd_q[WIDTH-1]),
        .divisor_i  (dvs_q),
        .rem_o      (step_rem),
        .quot_bit_o (step_quot_bit)
    );

    assign div_if.req_ready  = (state_q == S_IDLE) & ~div_if.cancel;
    assign div_if.resp_valid = resp_valid_q;
    assign div_if.busy       = busy_q;
    assign div_if.resp_quot  = quot_q;
    assign div_if.resp_rem   = rem_out_q;

    always_comb begin
        accept     = div_if.req_valid & div_if.req_ready;
        src1_neg   = div_if.req_signed & div_if.req_src1[WIDTH-1];
        src2_neg   = div_if.req_signed & div_if.req_src2[WIDTH-1];

        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        quot_d     = quot_q;
        rem_out_d  = rem_out_q;

        // Cancel overrides everything; outputs keep their last value.
        if (div_if.cancel) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (div_if.req_src2 == '0) begin
                            quot_d    = DIV_ZERO_QUOT[WIDTH-1:0];
                            rem_out_d = div_if.req_src1;
                            state_d   = S_DONE;
                        end else begin
                            neg_quot_d = src1_neg ^ src2_neg;
                            neg_rem_d  = src1_neg;
                            dvd_d      = src1_neg ? -div_if.req_src1 : div_if.req_src1;
                            dvs_d      = src2_neg ? -div_if.req_src2 : div_if.req_src2;
                            acc_d      = '0;
                            cnt_d      = '0;
                            state_d    = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_d = step_rem;
                    dvd_d = {dvd_q[WIDTH-2:0], step_quot_bit};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    quot_d    = neg_quot_q ? -dvd_q : dvd_q;
                    rem_out_d = neg_rem_q ? -acc_q : acc_q;
                    state_d   = S_DONE;
                end
                S_DONE: begin
                    if (div_if.resp_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d       = (state_d != S_IDLE);
        resp_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            dvd_q        <= '0;
            dvs_q        <= '0;
            neg_quot_q   <= 1'b0;
            neg_rem_q    <= 1'b0;
            quot_q       <= '0;
            rem_out_q    <= '0;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            dvd_q        <= dvd_d;
            dvs_q        <= dvs_d;
            neg_quot_q   <= neg_quot_d;
            neg_rem_q    <= neg_rem_d;
            quot_q       <= quot_d;
            rem_out_q    <= rem_out_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
        end
    end
endmodule

// File: tb/tb_ex_div_ctrl.sv
// Directed self-checking bench for ex_div_ctrl with hand-computed results.
module tb_ex_div_ctrl;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    ex_div_if #(.WIDTH(32)) div_if ();

    ex_div_ctrl #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .div_if (div_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Drive one request at the falling edge and let the next rising edge accept it.
    task automatic startOp(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        div_if.req_valid  = 1'b1;
        div_if.req_signed = sgn;
        div_if.req_src1   = a;
        div_if.req_src2   = b;
        @(posedge clk);
        #1;
        div_if.req_valid  = 1'b0;
        div_if.req_src1   = 32'hDEAD_BEEF;
        div_if.req_src2   = 32'h0;
    endtask

    // Run one operation; latency counts edges including the accept edge.
    task automatic applyStimulus(input string tag, input logic sgn, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] expQ,
                                 input logic [31:0] expR, input int expLat);
        int   edges;
        logic stallOk;
        stallOk = 1'b1;
        startOp(sgn, a, b);
        edges = 1;
        while (!div_if.resp_valid && edges < 100) begin
            if (!div_if.busy || div_if.req_ready) stallOk = 1'b0;
            @(posedge clk);
            #1;
            edges++;
        end
        checkOutput({tag, "_lat"}, edges, expLat);
        checkOutput({tag, "_stall"}, {31'd0, stallOk}, 32'd1);
        checkOutput({tag, "_quot"}, div_if.resp_quot, expQ);
        checkOutput({tag, "_rem"}, div_if.resp_rem, expR);
    endtask

    task automatic consumeResult(input string tag);
        @(negedge clk);
        div_if.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        div_if.resp_ready = 1'b0;
        checkOutput({tag, "_vld_drop"}, {31'd0, div_if.resp_valid}, 32'd0);
        checkOutput({tag, "_idle"}, {31'd0, div_if.busy}, 32'd0);
    endtask

    initial begin
        logic        stable;
        logic        everValid;
        logic [31:0] holdQ;
        logic [31:0] holdR;
        errors = 0;
        checks = 0;
        rst = 1'b1;
        div_if.req_valid  = 1'b0;
        div_if.req_signed = 1'b0;
        div_if.req_src1   = 32'h0;
        div_if.req_src2   = 32'h0;
        div_if.resp_ready = 1'b0;
        div_if.cancel     = 1'b0;
        #12;
        checkOutput("rst_req_ready", {31'd0, div_if.req_ready}, 32'd1);
        checkOutput("rst_resp_valid", {31'd0, div_if.resp_valid}, 32'd0);
        checkOutput("rst_quot", div_if.resp_quot, 32'h0);
        checkOutput("rst_rem", div_if.resp_rem, 32'h0);
        checkOutput("rst_busy", {31'd0, div_if.busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34);
        consumeResult("u100_7");
        applyStimulus("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34);
        consumeResult("s-7_2");
        applyStimulus("u-7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 34);
        consumeResult("u-7_2");
        applyStimulus("s_div0", 1'b1, 32'h1234, 32'h0, 32'hFFFF_FFFF, 32'h1234, 1);
        consumeResult("s_div0");
        applyStimulus("u_div0", 1'b0, 32'h1234, 32'h0, 32'hFFFF_FFFF, 32'h1234, 1);
        consumeResult("u_div0");
        applyStimulus("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 34);

        // Back-pressure: result must hold while EX is not ready.
        stable = 1'b1;
        holdQ  = div_if.resp_quot;
        holdR  = div_if.resp_rem;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (!div_if.resp_valid || div_if.resp_quot !== holdQ || div_if.resp_rem !== holdR)
                stable = 1'b0;
        end
        checkOutput("bp_stable", {31'd0, stable}, 32'd1);
        consumeResult("bp");
        checkOutput("bp_quot_kept", div_if.resp_quot, 32'h8000_0000);
        checkOutput("bp_req_ready", {31'd0, div_if.req_ready}, 32'd1);
        applyStimulus("b2b_45_6", 1'b0, 32'd45, 32'd6, 32'd7, 32'd3, 34);
        consumeResult("b2b_45_6");

        // Cancel part-way through the iterations.
        startOp(1'b0, 32'd1000, 32'd7);
        repeat (15) @(posedge clk);
        @(negedge clk);
        div_if.cancel = 1'b1;
        @(posedge clk);
        #1;
        div_if.cancel = 1'b0;
        checkOutput("cancel_busy", {31'd0, div_if.busy}, 32'd0);
        everValid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (div_if.resp_valid) everValid = 1'b1;
            @(posedge clk);
            #1;
        end
        checkOutput("cancel_no_valid", {31'd0, everValid}, 32'd0);
        applyStimulus("u20_3", 1'b0, 32'd20, 32'd3, 32'd6, 32'd2, 34);
        consumeResult("u20_3");

        // Cancel in IDLE blocks acceptance.
        @(negedge clk);
        div_if.cancel    = 1'b1;
        div_if.req_valid = 1'b1;
        div_if.req_src1  = 32'd50;
        div_if.req_src2  = 32'd5;
        #1;
        checkOutput("idle_cancel_ready", {31'd0, div_if.req_ready}, 32'd0);
        @(posedge clk);
        #1;
        div_if.cancel    = 1'b0;
        div_if.req_valid = 1'b0;
        checkOutput("idle_cancel_busy", {31'd0, div_if.busy}, 32'd0);

        // Asynchronous reset between edges during CALC.
        startOp(1'b0, 32'd500, 32'd7);
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("arst_busy", {31'd0, div_if.busy}, 32'd0);
        checkOutput("arst_valid", {31'd0, div_if.resp_valid}, 32'd0);
        checkOutput("arst_ready", {31'd0, div_if.req_ready}, 32'd1);
        checkOutput("arst_quot", div_if.resp_quot, 32'h0);
        checkOutput("arst_rem", div_if.resp_rem, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus("u9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 34);
        consumeResult("u9_3");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
